// File: rtl/timer_count_sequencer.sv
// Egg-timer datapath: 1 Hz prescaler, BCD mm:ss set/countdown, cntfin flag
// and finish-mode alarm blink, all driven by the controller's 3-bit mode code.
module timer_count_sequencer #(
    parameter int TICK_DIV    = 50000000,
    parameter int BLINK_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_mode,
    input  logic       i_inc_key,
    output logic       o_tick,
    output logic [3:0] o_sec_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_min_tens,
    output logic       o_cntfin,
    output logic       o_alarm_led
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [2:0] M_SETSEC = 3'd0;
    localparam logic [2:0] M_SETMIN = 3'd1;
    localparam logic [2:0] M_START  = 3'd3;
    localparam logic [2:0] M_FINISH = 3'd4;
    localparam logic [2:0] M_RESET  = 3'd5;

    logic [PW-1:0] r_presc;
    logic [BW-1:0] r_blink;
    logic [2:0]    r_mode_q;
    logic          r_inc_q;
    logic          r_tick;
    logic          r_cntfin;
    logic          r_alarm;
    logic [3:0]    r_so, r_st, r_mo, r_mt;
    logic [3:0]    w_so, w_st, w_mo, w_mt;

    logic w_entry_start, w_entry_fin, w_presc_clr, w_wrap, w_tick, w_inc_rise, w_zero;

    assign w_entry_start = (i_mode == M_START)  && (r_mode_q != M_START);
    assign w_entry_fin   = (i_mode == M_FINISH) && (r_mode_q != M_FINISH);
    assign w_presc_clr   = (i_mode == M_RESET) || w_entry_start;
    assign w_wrap        = (r_presc == PW'(TICK_DIV - 1));
    // Clearing on start entry also swallows a tick landing in that same cycle.
    assign w_tick        = w_wrap && !w_presc_clr;
    assign w_inc_rise    = i_inc_key && !r_inc_q;
    assign w_zero        = (r_so == 4'd0) && (r_st == 4'd0) && (r_mo == 4'd0) && (r_mt == 4'd0);

    always_comb begin
        w_so = r_so;
        w_st = r_st;
        w_mo = r_mo;
        w_mt = r_mt;
        case (i_mode)
            M_SETSEC: if (w_inc_rise) begin
                if (r_so == 4'd9) begin
                    w_so = 4'd0;
                    w_st = (r_st == 4'd5) ? 4'd0 : r_st + 4'd1;
                end else begin
                    w_so = r_so + 4'd1;
                end
            end
            M_SETMIN: if (w_inc_rise) begin
                if (r_mo == 4'd9) begin
                    w_mo = 4'd0;
                    w_mt = (r_mt == 4'd9) ? 4'd0 : r_mt + 4'd1;
                end else begin
                    w_mo = r_mo + 4'd1;
                end
            end
            // Countdown saturates at 00:00 rather than wrapping to 99:59.
            M_START: if (w_tick && !w_zero) begin
                if (r_so != 4'd0) begin
                    w_so = r_so - 4'd1;
                end else if (r_st != 4'd0) begin
                    w_so = 4'd9;
                    w_st = r_st - 4'd1;
                end else begin
                    w_so = 4'd9;
                    w_st = 4'd5;
                    if (r_mo != 4'd0) begin
                        w_mo = r_mo - 4'd1;
                    end else begin
                        w_mo = 4'd9;
                        w_mt = r_mt - 4'd1;
                    end
                end
            end
            M_RESET: begin
                w_so = 4'd0;
                w_st = 4'd0;
                w_mo = 4'd0;
                w_mt = 4'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc  <= '0;
            r_blink  <= '0;
            r_mode_q <= 3'd0;
            r_inc_q  <= 1'b0;
            r_tick   <= 1'b0;
            r_cntfin <= 1'b0;
            r_alarm  <= 1'b0;
            r_so     <= 4'd0;
            r_st     <= 4'd0;
            r_mo     <= 4'd0;
            r_mt     <= 4'd0;
        end else begin
            r_mode_q <= (i_mode == M_RESET) ? 3'd0 : i_mode;
            r_presc  <= (w_presc_clr || w_wrap) ? '0 : r_presc + 1'b1;
            r_tick   <= w_tick;
            r_inc_q  <= i_inc_key;
            r_so     <= w_so;
            r_st     <= w_st;
            r_mo     <= w_mo;
            r_mt     <= w_mt;
            r_cntfin <= ((i_mode == M_START) || (i_mode == M_FINISH)) && w_zero;
            if (i_mode == M_FINISH) begin
                if (w_entry_fin) begin
                    r_blink <= '0;
                    r_alarm <= 1'b1;
                end else if (w_tick) begin
                    if (r_blink == BW'(BLINK_TICKS - 1)) begin
                        r_blink <= '0;
                        r_alarm <= !r_alarm;
                    end else begin
                        r_blink <= r_blink + 1'b1;
                    end
                end
            end else begin
                r_blink <= '0;
                r_alarm <= 1'b0;
            end
        end
    end

    assign o_tick      = r_tick;
    assign o_sec_ones  = r_so;
    assign o_sec_tens  = r_st;
    assign o_min_ones  = r_mo;
    assign o_min_tens  = r_mt;
    assign o_cntfin    = r_cntfin;
    assign o_alarm_led = r_alarm;
endmodule
